// File: rtl/mos6502_pkg.sv
// Shared types and constants for the tinymos6502 cycle sequencer.
//   seq_state_t : sequencer top-level state
//   push_sel_t  : stack push source select
//   *_VEC_DEF   : default interrupt/reset vector addresses
//   T_* / T_MAX : T-state numbers used by the entry sequence
package mos6502_pkg;

  localparam int unsigned T_W    = 3;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned PUSH_W = 2;

  localparam logic [T_W-1:0] T_MAX      = T_W'(6);
  localparam logic [T_W-1:0] T_PUSH_PCH = T_W'(2);
  localparam logic [T_W-1:0] T_PUSH_PCL = T_W'(3);
  localparam logic [T_W-1:0] T_PUSH_P   = T_W'(4);
  localparam logic [T_W-1:0] T_VEC_LO   = T_W'(5);
  localparam logic [T_W-1:0] T_VEC_HI   = T_W'(6);

  localparam logic [ADDR_W-1:0] RST_VEC_DEF = 16'hFFFC;
  localparam logic [ADDR_W-1:0] NMI_VEC_DEF = 16'hFFFA;
  localparam logic [ADDR_W-1:0] IRQ_VEC_DEF = 16'hFFFE;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    INT_SEQ   = 2'd1,
    RESET_SEQ = 2'd2
  } seq_state_t;

  typedef enum logic [PUSH_W-1:0] {
    PUSH_NONE = 2'd0,
    PUSH_PCH  = 2'd1,
    PUSH_PCL  = 2'd2,
    PUSH_P    = 2'd3
  } push_sel_t;

  // Push source for a given entry-sequence T-state (T2..T4), none otherwise.
  function automatic push_sel_t push_for_t(input logic [T_W-1:0] t);
    unique case (t)
      T_PUSH_PCH: push_for_t = PUSH_PCH;
      T_PUSH_PCL: push_for_t = PUSH_PCL;
      T_PUSH_P:   push_for_t = PUSH_P;
      default:    push_for_t = PUSH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// NMI rising-edge detector with a sticky pending flag.
//   clk, rst : core clock, async active-high reset
//   nmi      : raw NMI level
//   clr      : clear request for the pending flag
//   pend     : registered pending flag
//   rise_c   : combinational rising edge seen this cycle
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic nmi,
  input  logic clr,
  output logic pend,
  output logic rise_c
);

  logic nmi_q;

  assign rise_c = nmi & ~nmi_q;

  // A fresh edge wins over a clear so an NMI arriving while the previous one
  // is being retired is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      nmi_q <= nmi;
      if (rise_c) begin
        pend <= 1'b1;
      end else if (clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Cycle-level sequencer for the tinymos6502 core: T-state tracking,
// SYNC/RW/RDY handling, boundary arbitration of reset/NMI/IRQ/BRK and the
// 7-cycle interrupt/reset entry sequence.
//   inputs : clk, rst, rdy, irq, nmi, i_flag, insn_last, brk_op
//   outputs: t_state, sync, rw, int_active, force_brk, push_sel, b_flag,
//            vec_addr, vec_lo, vec_hi, set_i
module cpu_cycle_sequencer
  import mos6502_pkg::*;
#(
  parameter logic [15:0] RST_VEC = RST_VEC_DEF,
  parameter logic [15:0] NMI_VEC = NMI_VEC_DEF,
  parameter logic [15:0] IRQ_VEC = IRQ_VEC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              irq,
  input  logic              nmi,
  input  logic              i_flag,
  input  logic              insn_last,
  input  logic              brk_op,
  output logic [T_W-1:0]    t_state,
  output logic              sync,
  output logic              rw,
  output logic              int_active,
  output logic              force_brk,
  output logic [PUSH_W-1:0] push_sel,
  output logic              b_flag,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              vec_lo,
  output logic              vec_hi,
  output logic              set_i
);

  seq_state_t        state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  logic              brk_q, brk_d;
  logic              vnmi_q, vnmi_d;
  logic              nmi_pend, nmi_rise_c, nmi_clr, nmi_take, stall;
  logic [ADDR_W-1:0] vec_base;

  nmi_edge_detect u_nmi (
    .clk    (clk),
    .rst    (rst),
    .nmi    (nmi),
    .clr    (nmi_clr),
    .pend   (nmi_pend),
    .rise_c (nmi_rise_c)
  );

  // An edge in the current cycle counts as pending so it is not one cycle late.
  assign nmi_take = nmi_pend | nmi_rise_c;
  // Read cycles stall on rdy low; write cycles always advance.
  assign stall    = ~rdy & rw;
  assign t_state  = t_q;
  assign vec_base = (state_q == RESET_SEQ) ? RST_VEC : (vnmi_q ? NMI_VEC : IRQ_VEC);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_SEQ;
      t_q     <= '0;
      brk_q   <= 1'b0;
      vnmi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      brk_q   <= brk_d;
      vnmi_q  <= vnmi_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    brk_d   = brk_q;
    vnmi_d  = vnmi_q;
    nmi_clr = (state_q == RESET_SEQ);
    if (!stall) begin
      unique case (state_q)
        RUN: begin
          if (insn_last) begin
            t_d = '0;
            if (nmi_take || (irq && !i_flag)) begin
              state_d = INT_SEQ;
              brk_d   = 1'b0;
            end
          end else if ((t_q == T_W'(1)) && brk_op) begin
            // BRK joins the entry sequence at its first push cycle.
            state_d = INT_SEQ;
            t_d     = T_PUSH_PCH;
            brk_d   = 1'b1;
          end else begin
            t_d = t_q + T_W'(1);
          end
        end
        INT_SEQ: begin
          if (t_q == T_PUSH_P) vnmi_d = nmi_take;
          if ((t_q == T_VEC_LO) && vnmi_q) nmi_clr = 1'b1;
          if (t_q == T_MAX) begin
            state_d = RUN;
            t_d     = '0;
          end else begin
            t_d = t_q + T_W'(1);
          end
        end
        RESET_SEQ: begin
          if (t_q == T_MAX) begin
            state_d = RUN;
            t_d     = '0;
          end else begin
            t_d = t_q + T_W'(1);
          end
        end
        default: begin
          state_d = RESET_SEQ;
          t_d     = '0;
        end
      endcase
    end
  end

  // Output decode of the current state.
  always_comb begin
    sync       = 1'b0;
    rw         = 1'b1;
    int_active = 1'b0;
    force_brk  = 1'b0;
    push_sel   = PUSH_W'(PUSH_NONE);
    b_flag     = 1'b0;
    vec_lo     = 1'b0;
    vec_hi     = 1'b0;
    set_i      = 1'b0;
    vec_addr   = RST_VEC;
    unique case (state_q)
      RUN: begin
        sync = (t_q == T_W'(0));
      end
      INT_SEQ, RESET_SEQ: begin
        int_active = 1'b1;
        vec_lo     = (t_q == T_VEC_LO);
        vec_hi     = (t_q == T_VEC_HI);
        set_i      = (t_q == T_VEC_HI);
        if (t_q >= T_VEC_LO) begin
          vec_addr = vec_base + ADDR_W'(t_q == T_VEC_HI);
        end
        if (state_q == INT_SEQ) begin
          sync      = (t_q == T_W'(0));
          force_brk = (t_q == T_W'(0));
          b_flag    = brk_q;
          if ((t_q >= T_PUSH_PCH) && (t_q <= T_PUSH_P)) begin
            rw       = 1'b0;
            push_sel = PUSH_W'(push_for_t(t_q));
          end
        end
      end
      default: ;
    endcase
  end

  // T-state must stay within the 7-cycle window.
  a_t_state_max: assert property (@(posedge clk) disable iff (rst) t_q <= T_MAX);

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Self-checking bench for cpu_cycle_sequencer: directed scenarios followed by
// randomized traffic, all checked against a cycle-plan reference model.
module tb_cpu_cycle_sequencer;

  logic        clk = 1'b0;
  logic        rst, rdy, irq, nmi, i_flag, insn_last, brk_op;
  logic [2:0]  t_state;
  logic        sync, rw, int_active, force_brk, b_flag, vec_lo, vec_hi, set_i;
  logic [1:0]  push_sel;
  logic [15:0] vec_addr;

  always #5 clk = ~clk;

  cpu_cycle_sequencer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .irq(irq), .nmi(nmi), .i_flag(i_flag),
    .insn_last(insn_last), .brk_op(brk_op), .t_state(t_state), .sync(sync),
    .rw(rw), .int_active(int_active), .force_brk(force_brk), .push_sel(push_sel),
    .b_flag(b_flag), .vec_addr(vec_addr), .vec_lo(vec_lo), .vec_hi(vec_hi), .set_i(set_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = running instructions, 1 = interrupt entry,
  // 2 = reset entry; m_t is the cycle number within the current phase.
  int m_mode, m_t;
  bit m_brk, m_vnmi, m_pend, m_nmi_prev;
  // Decoder stand-in: current instruction length and whether it is BRK.
  int insn_len = 2;
  bit insn_brk, want_brk;
  int brk_pct = 0;

  task automatic pick_insn();
    insn_brk = want_brk || (brk_pct != 0 && $urandom_range(99) < brk_pct);
    want_brk = 1'b0;
    insn_len = $urandom_range(7, 1);
  endtask

  function automatic bit exp_rw();
    return !(m_mode == 1 && m_t >= 2 && m_t <= 4);
  endfunction

  task automatic model_reset();
    m_mode = 2; m_t = 0; m_brk = 0; m_vnmi = 0; m_pend = 0; m_nmi_prev = 0;
  endtask

  task automatic check_outputs();
    bit          seq, in_int, pushc;
    logic [9:0]  exp_ctl;
    logic [15:0] base;
    seq    = (m_mode != 0);
    in_int = (m_mode == 1);
    pushc  = in_int && m_t >= 2 && m_t <= 4;
    exp_ctl = {m_t == 0 && m_mode != 2, exp_rw(), seq, in_int && m_t == 0,
               pushc ? 2'(m_t - 1) : 2'd0, in_int && m_brk,
               seq && m_t == 5, seq && m_t == 6, seq && m_t == 6};
    check("t_state", 32'(t_state), 32'(m_t));
    check("ctl", {sync, rw, int_active, force_brk, push_sel, b_flag, vec_lo, vec_hi, set_i}, exp_ctl);
    if (seq && m_t >= 5) begin
      base = (m_mode == 2) ? 16'hFFFC : (m_vnmi ? 16'hFFFA : 16'hFFFE);
      check("vec_addr", vec_addr, base + ((m_t == 6) ? 16'd1 : 16'd0));
    end
  endtask

  // One clock cycle: check current outputs, drive decoder inputs, advance model.
  task automatic step();
    bit rise, take, clr;
    check_outputs();
    insn_last = 1'b0;
    brk_op    = 1'b0;
    if (m_mode == 0) begin
      if (insn_brk) brk_op = (m_t == 1);
      else          insn_last = (m_t == insn_len - 1);
    end
    rise = nmi && !m_nmi_prev;
    m_nmi_prev = nmi;
    take = m_pend || rise;
    clr  = (m_mode == 2);
    if (!(!rdy && exp_rw())) begin
      case (m_mode)
        0: begin
          if (insn_last) begin
            if (take || (irq && !i_flag)) begin m_mode = 1; m_brk = 0; end
            m_t = 0;
            if (m_mode == 0) pick_insn();
          end else if (m_t == 1 && brk_op) begin
            m_mode = 1; m_t = 2; m_brk = 1;
          end else begin
            m_t++;
          end
        end
        default: begin
          if (m_mode == 1 && m_t == 4) m_vnmi = take;
          if (m_mode == 1 && m_t == 5 && m_vnmi) clr = 1;
          if (m_t == 6) begin m_mode = 0; m_t = 0; pick_insn(); end
          else m_t++;
        end
      endcase
    end
    if (rise) m_pend = 1;
    else if (clr) m_pend = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until(input int mode, input int t, input int limit, input string tag);
    int n = 0;
    while (!(m_mode == mode && m_t == t) && n < limit) begin
      step();
      n++;
    end
    check(tag, {int_active, t_state}, {mode != 0, 3'(t)});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_t"}, 32'(t_state), 32'd0);
    check({tag, "_ctl"}, {sync, rw, int_active, force_brk, push_sel, b_flag, vec_lo, vec_hi, set_i},
          10'b0110000000);
    check({tag, "_vec"}, vec_addr, 16'hFFFC);
  endtask

  // Asserts rst mid-cycle (async), holds it, releases on a falling edge.
  task automatic do_reset(input string tag);
    nmi = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_values(tag);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; irq = 1'b0; nmi = 1'b0; i_flag = 1'b0;
    insn_last = 1'b0; brk_op = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;

    // Reset release: 7 read cycles then the first opcode fetch.
    for (int k = 0; k < 7; k++) begin
      check("rst_rw", rw, 1'b1);
      step();
    end
    check("rst_sync8", {int_active, sync}, 2'b01);
    repeat (4) step();

    // IRQ taken with I clear.
    irq = 1'b1; i_flag = 1'b0;
    run_until(1, 0, 40, "irq_enter");
    check("irq_force_brk", {sync, force_brk}, 2'b11);
    run_until(1, 2, 5, "irq_t2");
    check("irq_push_pch", {rw, push_sel, b_flag}, 4'b0010);
    irq = 1'b0;
    run_until(1, 5, 5, "irq_t5");
    check("irq_vec_lo", vec_addr, 16'hFFFE);
    step();
    check("irq_vec_hi", vec_addr, 16'hFFFF);
    repeat (3) step();

    // IRQ masked by I flag.
    irq = 1'b1; i_flag = 1'b1;
    for (int k = 0; k < 25; k++) begin
      check("irq_masked", int_active, 1'b0);
      step();
    end
    irq = 1'b0; i_flag = 1'b0;

    // BRK hijacked by an NMI edge at T3.
    want_brk = 1'b1;
    run_until(0, 0, 20, "brk_wait_t0");
    step();
    run_until(1, 3, 20, "brk_t3");
    nmi = 1'b1;
    step();
    check("brk_bflag_t4", {rw, push_sel, b_flag}, 4'b0111);
    run_until(1, 5, 5, "brk_t5");
    check("brk_nmi_vec_lo", vec_addr, 16'hFFFA);
    step();
    check("brk_nmi_vec_hi", vec_addr, 16'hFFFB);
    nmi = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("nmi_retired", int_active && m_mode == 0, 1'b0);
      step();
    end

    // rdy low for 3 cycles at T5, then during a write cycle.
    irq = 1'b1;
    run_until(1, 5, 40, "stall_t5_enter");
    irq = 1'b0; rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_t5_hold", {t_state, vec_addr}, {3'd5, 16'hFFFE});
    end
    rdy = 1'b1;
    step();
    check("stall_t5_resume", 32'(t_state), 32'd6);
    irq = 1'b1;
    run_until(1, 2, 40, "stall_t2_enter");
    irq = 1'b0; rdy = 1'b0;
    step();
    check("write_no_stall", 32'(t_state), 32'd3);
    rdy = 1'b1;
    repeat (6) step();

    // Reset during an interrupt entry sequence.
    irq = 1'b1;
    run_until(1, 3, 40, "rst_mid_enter");
    irq = 1'b0;
    do_reset("rst_mid");
    repeat (12) step();

    // Randomized traffic.
    brk_pct = 8;
    for (int k = 0; k < 4000; k++) begin
      rdy = ($urandom_range(4) != 0);
      if ($urandom_range(15) == 0) irq = ~irq;
      if ($urandom_range(31) == 0) i_flag = $urandom_range(1);
      nmi = ($urandom_range(10) == 0);
      if ($urandom_range(700) == 0) do_reset("rst_rand");
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
